// File: rtl/dma_channel_arbiter_pkg.sv
// rtl/dma_channel_arbiter_pkg.sv - shared types and helpers for the DMA channel arbiter
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int DMA_WORD_BYTES = 4;

  // Channel-id width; a single channel still needs one bit to index it.
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// rtl/dma_channel_arbiter_if.sv - command port between the arbiter and the wishbone master agent
interface dma_channel_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  o_start;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  i_done;
  logic [DATA_WIDTH-1:0] i_rdata;

  modport master (
    output o_start, o_we, o_addr, o_wdata,
    input  i_done, i_rdata
  );

  modport slave (
    input  o_start, o_we, o_addr, o_wdata,
    output i_done, i_rdata
  );
endinterface

// File: rtl/dma_channel_arbiter_rr_picker.sv
// rtl/dma_channel_arbiter_rr_picker.sv - combinational round-robin select of the next pending channel
module dma_rr_picker
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]              i_pend,
  input  logic [ch_id_w(NUM_CH)-1:0]     i_rr_ptr,
  output logic                           o_valid,
  output logic [ch_id_w(NUM_CH)-1:0]     o_grant_id
);
  localparam int ID_W = ch_id_w(NUM_CH);

  int idx;

  // Scan from the farthest offset down so the first set bit at or after rr_ptr wins.
  always_comb begin
    o_valid    = 1'b0;
    o_grant_id = '0;
    idx        = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(i_rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (i_pend[ID_W'(idx)]) begin
        o_valid    = 1'b1;
        o_grant_id = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - round-robin share of one agent command port; optional watchdog via DMA_ARB_TIMEOUT_EN
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_CH-1:0]                  i_ch_start,
  input  logic [NUM_CH-1:0]                  i_ch_we,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  i_ch_addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  i_ch_wdata,
  output logic [NUM_CH-1:0]                  o_ch_done,
  output logic [DATA_WIDTH-1:0]              o_ch_rdata,
  output logic [NUM_CH-1:0]                  o_ch_err,
  dma_channel_arbiter_if.master              agent,
  output logic [$clog2(NUM_CH)-1:0]          o_grant_id,
  output logic                               o_busy
);
  localparam int ID_W = ch_id_w(NUM_CH);

  arb_state_e                       state_q, state_d;
  logic [NUM_CH-1:0]                pend_q, pend_d;
  logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                  grant_q, grant_d;
  logic [NUM_CH-1:0]                slot_we_q, slot_we_d;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
  logic                             start_q, start_d;
  logic                             we_q, we_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0]            wdata_q, wdata_d;
  logic                             pick_valid;
  logic [ID_W-1:0]                  pick_id;
  logic                             complete;

`ifdef DMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

  dma_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .i_pend     (pend_q),
    .i_rr_ptr   (rr_ptr_q),
    .o_valid    (pick_valid),
    .o_grant_id (pick_id)
  );

  assign agent.o_start = start_q;
  assign agent.o_we    = we_q;
  assign agent.o_addr  = addr_q;
  assign agent.o_wdata = wdata_q;
  assign o_grant_id    = grant_q;
  assign o_busy        = (state_q != IDLE);

  // Next-state: pending capture, grant sequencing and same-cycle completion routing.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    start_d      = 1'b0;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    o_ch_done    = '0;
    o_ch_err     = '0;
    o_ch_rdata   = agent.i_rdata;
    complete     = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    // A slot already holding a command keeps it until that command completes.
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_ch_start[k] && !pend_q[k]) begin
        pend_d[k]       = 1'b1;
        slot_we_d[k]    = i_ch_we[k];
        slot_addr_d[k]  = i_ch_addr[k];
        slot_wdata_d[k] = i_ch_wdata[k];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          grant_d = pick_id;
          start_d = 1'b1;
          we_d    = slot_we_q[pick_id];
          addr_d  = slot_addr_q[pick_id];
          wdata_d = slot_wdata_q[pick_id];
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (agent.i_done) begin
          o_ch_done[grant_q] = 1'b1;
          complete           = 1'b1;
        end
`ifdef DMA_ARB_TIMEOUT_EN
        else if (expire) begin
          o_ch_done[grant_q] = 1'b1;
          o_ch_err[grant_q]  = 1'b1;
          o_ch_rdata         = '0;
          complete           = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (complete) begin
          pend_d[grant_q] = 1'b0;
          rr_ptr_d        = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          state_d         = IDLE;
          we_d            = 1'b0;
          addr_d          = '0;
          wdata_d         = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All arbiter state, including the registered agent command outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      slot_we_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      start_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      start_q      <= start_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifdef DMA_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - self-checking bench for dma_channel_arbiter
module tb_dma_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int TMO    = 16;

  logic                      i_clk;
  logic                      i_rst_n;
  logic [NUM_CH-1:0]         ch_start;
  logic [NUM_CH-1:0]         ch_we;
  logic [NUM_CH-1:0][AW-1:0] ch_addr;
  logic [NUM_CH-1:0][DW-1:0] ch_wdata;
  logic [NUM_CH-1:0]         ch_done;
  logic [NUM_CH-1:0]         ch_err;
  logic [DW-1:0]             ch_rdata;
  logic [1:0]                grant_id;
  logic                      busy;

  dma_channel_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dma_channel_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ch_start (ch_start),
    .i_ch_we    (ch_we),
    .i_ch_addr  (ch_addr),
    .i_ch_wdata (ch_wdata),
    .o_ch_done  (ch_done),
    .o_ch_rdata (ch_rdata),
    .o_ch_err   (ch_err),
    .agent      (bus),
    .o_grant_id (grant_id),
    .o_busy     (busy)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0]      we;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          have_cur;
  int          tests;
  int          fails;
  int          start_cnt;
  bit          mon_start_seen;
  bit          mon_done_seen;
  bit          ag_pending;
  bit          ag_hang;
  int          ag_cnt;
  int          ag_delay;
  logic [31:0] ag_addr;
  logic [31:0] ag_xor;
  vec_t        vecs [8];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ch, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.ch = ch; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    return e;
  endfunction

  task automatic agent_step();
    bus.i_done  = 1'b0;
    bus.i_rdata = 32'h5A5A_5A5A;
    if (ag_pending) begin
      if (ag_cnt == 0) begin
        bus.i_done  = 1'b1;
        bus.i_rdata = ag_addr ^ ag_xor;
        ag_pending  = 1'b0;
      end else begin
        ag_cnt--;
      end
    end
    if (bus.o_start && !ag_hang) begin
      ag_pending = 1'b1;
      ag_cnt     = ag_delay;
      ag_addr    = bus.o_addr;
    end
  endtask

  task automatic mon_step();
    logic [3:0] onehot;
    mon_start_seen = 1'b0;
    mon_done_seen  = 1'b0;
    if (bus.o_start) begin
      mon_start_seen = 1'b1;
      start_cnt++;
      chk("start_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        cur      = sb.pop_front();
        have_cur = 1'b1;
        chk("grant_id", 64'(grant_id), 64'(cur.ch));
        chk("o_addr",   64'(bus.o_addr), 64'(cur.addr));
        chk("o_we",     64'(bus.o_we), 64'(cur.we));
        chk("o_wdata",  64'(bus.o_wdata), 64'(cur.wdata));
      end
    end
    if (ch_done != 4'b0 || ch_err != 4'b0) begin
      mon_done_seen = 1'b1;
      chk("done_expected", 64'(have_cur), 64'd1);
      if (have_cur) begin
        onehot = 4'b0001 << cur.ch;
        chk("ch_done_onehot", 64'(ch_done), 64'(onehot));
        chk("ch_err",         64'(ch_err), 64'(cur.err ? onehot : 4'b0));
        chk("ch_rdata",       64'(ch_rdata), 64'(cur.rdata));
        have_cur = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    agent_step();
    #1;
    mon_step();
  endtask

  task automatic pulse(input logic [3:0] m);
    ch_start = m;
    tick();
    ch_start = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || have_cur) && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_drain_bounded"}, 64'(n < 300), 64'd1);
    repeat (4) tick();
  endtask

  task automatic wait_start(input string name, output int lat);
    lat = 0;
    while (!mon_start_seen && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_start_seen"}, 64'(mon_start_seen), 64'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mon_done_seen && lat < 60);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_o_start"},  64'(bus.o_start), 64'd0);
    chk({p, "_o_we"},     64'(bus.o_we), 64'd0);
    chk({p, "_o_addr"},   64'(bus.o_addr), 64'd0);
    chk({p, "_o_wdata"},  64'(bus.o_wdata), 64'd0);
    chk({p, "_ch_done"},  64'(ch_done), 64'd0);
    chk({p, "_ch_err"},   64'(ch_err), 64'd0);
    chk({p, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({p, "_busy"},     64'(busy), 64'd0);
  endtask

  initial begin
    vec_t       v;
    logic [1:0] id;
    int         lat;
    int         s0;

    tests = 0; fails = 0; start_cnt = 0; have_cur = 1'b0;
    ag_pending = 1'b0; ag_hang = 1'b0; ag_cnt = 0; ag_delay = 0;
    ag_addr = '0; ag_xor = 32'hFFFF_FFFF;
    ch_start = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    bus.i_done = 1'b0; bus.i_rdata = '0;

    // Orders assume rr_ptr = 0 at vector 0 and follow from each preceding vector.
    vecs[0] = '{mask: 4'b1111, we: 4'b0101, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b1000, we: 4'b1000, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[2] = '{mask: 4'b1001, we: 4'b0001, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd0}};
    vecs[3] = '{mask: 4'b0110, we: 4'b0010, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[4] = '{mask: 4'b0101, we: 4'b0100, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
    vecs[5] = '{mask: 4'b1010, we: 4'b0000, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd3}};
    vecs[6] = '{mask: 4'b0011, we: 4'b0011, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[7] = '{mask: 4'b1110, we: 4'b1010, n: 3'd3, order: {2'd0, 2'd1, 2'd3, 2'd2}};

    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) tick();

    for (int s = 0; s < 8; s++) begin
      v = vecs[s];
      for (int k = 0; k < NUM_CH; k++) begin
        ch_addr[k]  = (32'(s) << 16) | (32'(k) << 8);
        ch_wdata[k] = 32'hC0DE_0000 | (32'(s) << 8) | 32'(k);
      end
      ch_we = v.we;
      for (int i = 0; i < int'(v.n); i++) begin
        id = v.order[i];
        sb.push_back(mk(id, v.we[id], ch_addr[id], ch_wdata[id], ch_addr[id] ^ ag_xor, 1'b0));
      end
      pulse(v.mask);
      drain($sformatf("vec%0d", s));
    end

    ch_we      = '0;
    ch_addr[0] = 32'h0000_1000;
    ch_wdata   = '0;
    ag_delay   = 2;
    ag_xor     = 32'h0000_1000 ^ 32'hDEAD_BEEF;
    sb.push_back(mk(2'd0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0));
    pulse(4'b0001);
    wait_start("single", lat);
    chk("single_start_latency", 64'(lat + 1), 64'd2);
    wait_done(lat);
    chk("single_done_latency", 64'(lat), 64'd3);
    chk("single_busy_at_done", 64'(busy), 64'd1);
    tick();
    chk("single_busy_fall", 64'(busy), 64'd0);
    ag_xor = 32'hFFFF_FFFF;
    repeat (2) tick();

    ag_delay = 3;
    s0 = start_cnt;
    ch_addr[0] = 32'h0000_0050;
    sb.push_back(mk(2'd0, 1'b0, 32'h0000_0050, 32'h0, ~32'h0000_0050, 1'b0));
    sb.push_back(mk(2'd1, 1'b0, 32'h0000_0200, 32'h0, ~32'h0000_0200, 1'b0));
    pulse(4'b0001);
    ch_addr[1] = 32'h0000_0200;
    pulse(4'b0010);
    ch_addr[1] = 32'h0000_0300;
    pulse(4'b0010);
    drain("dup");
    chk("dup_start_count", 64'(start_cnt - s0), 64'd2);
    ag_delay = 0;

`ifdef DMA_ARB_TIMEOUT_EN
    ag_hang = 1'b1;
    ch_addr[1] = 32'h0000_7000;
    ch_addr[2] = 32'h0000_8000;
    sb.push_back(mk(2'd1, 1'b0, 32'h0000_7000, 32'h0, 32'h0, 1'b1));
    sb.push_back(mk(2'd2, 1'b0, 32'h0000_8000, 32'h0, ~32'h0000_8000, 1'b0));
    pulse(4'b0010);
    ch_addr[1] = 32'h0000_7700;
    pulse(4'b0100);
    wait_start("tmo", lat);
    wait_done(lat);
    chk("tmo_expiry_cycles", 64'(lat), 64'(TMO + 1));
    ag_hang = 1'b0;
    drain("tmo");
`endif

    ag_hang = 1'b1;
    ch_addr[1] = 32'h0000_9000;
    ch_addr[2] = 32'h0000_9100;
    sb.push_back(mk(2'd1, 1'b0, 32'h0000_9000, 32'h0, ~32'h0000_9000, 1'b0));
    pulse(4'b0010);
    pulse(4'b0100);
    wait_start("rst", lat);
    repeat (3) tick();
    chk("rst_busy_before", 64'(busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check_zero("rst_wait");
    sb.delete();
    have_cur = 1'b0;
    #1;
    i_rst_n = 1'b1;
    s0 = start_cnt;
    repeat (10) tick();
    chk("rst_no_start_after_release", 64'(start_cnt - s0), 64'd0);
    ag_hang = 1'b0;
    ch_addr[2] = 32'h0000_A000;
    sb.push_back(mk(2'd2, 1'b0, 32'h0000_A000, 32'h0, ~32'h0000_A000, 1'b0));
    pulse(4'b0100);
    drain("post_rst");
    chk("post_rst_start_count", 64'(start_cnt - s0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
